// File: rtl/serial_load_ctrl_pkg.sv
// Shared types and constants for the serial load controller and its datapath.
package serial_load_ctrl_pkg;

   localparam int unsigned WORD_W_DEF = 16;
   localparam int unsigned TIMER_W    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_load_ctrl_shift_register.sv
// Serial-in/parallel-out shift register; shifts toward the MSB, new bit enters at bit 0.
module shift_register
   import serial_load_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = WORD_W_DEF
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)
         q <= '0;
      else if (en)
         q <= {q[WIDTH-2:0], din};
   end

endmodule

// File: rtl/serial_load_ctrl.sv
// Frame capture controller: FSM, bit counter and inter-bit idle timer around one shift register.
module serial_load_ctrl
   import serial_load_ctrl_pkg::*;
#(
   parameter int unsigned WORD_W  = WORD_W_DEF,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic              bit_i,
   input  logic              bit_valid_i,
   output logic [WORD_W-1:0] word_o,
   input  logic              word_ready_i,
   output logic              word_valid_o,
   output logic              busy_o,
   output logic              err_o
);

   localparam int unsigned CNT_W = $clog2(WORD_W) + 1;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [TIMER_W-1:0]   timer, timer_nxt;
   logic                 shift_en;
   logic                 err_nxt;
   logic                 last_bit;
   logic                 timer_expiring;

   assign last_bit       = (cnt == CNT_W'(WORD_W - 1));
   assign timer_expiring = (timer == TIMER_W'(TIMEOUT - 1));

   // State register
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; abort overrides every other transition
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start_i) state_nxt = SHIFT;
         SHIFT: begin
            if (bit_valid_i && last_bit)
               state_nxt = HOLD;
            else if (!bit_valid_i && timer_expiring)
               state_nxt = IDLE;
         end
         HOLD:  if (word_ready_i) state_nxt = start_i ? SHIFT : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort_i)
         state_nxt = IDLE;
   end

   // Output / datapath control; counter and timer clear on any entry to or exit from SHIFT
   always_comb begin
      shift_en  = (state == SHIFT) && bit_valid_i && !abort_i;
      err_nxt   = (state == SHIFT) && !bit_valid_i && !abort_i && timer_expiring;
      cnt_nxt   = '0;
      timer_nxt = '0;
      if (state == SHIFT && state_nxt == SHIFT) begin
         cnt_nxt   = shift_en ? cnt + CNT_W'(1) : cnt;
         timer_nxt = bit_valid_i ? '0 : timer + TIMER_W'(1);
      end
   end

   // Counter, timer and flag outputs, each a registered function of the next state
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         cnt          <= '0;
         timer        <= '0;
         busy_o       <= 1'b0;
         word_valid_o <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         cnt          <= cnt_nxt;
         timer        <= timer_nxt;
         busy_o       <= (state_nxt != IDLE);
         word_valid_o <= (state_nxt == HOLD);
         err_o        <= err_nxt;
      end
   end

   shift_register #(
      .WIDTH (WORD_W)
   ) u_shift (
      .clk    (clk),
      .resetb (resetb),
      .en     (shift_en),
      .din    (bit_i),
      .q      (word_o)
   );

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Self-checking bench: directed frame scenarios plus random traffic against a frame-level model.
module tb_serial_load_ctrl;

   localparam int unsigned W   = 16;
   localparam int unsigned TMO = 4;

   localparam int M_IDLE = 0;
   localparam int M_SHIFT = 1;
   localparam int M_HOLD = 2;

   logic         clk;
   logic         resetb;
   logic         start_i, abort_i, bit_i, bit_valid_i, word_ready_i;
   logic [W-1:0] word_o;
   logic         word_valid_o, busy_o, err_o;

   int checks;
   int failures;

   // Reference model: frame progress in plain integers
   int           m_mode;
   int           m_nbits;
   int           m_idle;
   logic [W-1:0] m_word;
   logic         m_err;

   serial_load_ctrl #(
      .WORD_W  (W),
      .TIMEOUT (TMO)
   ) dut (
      .clk          (clk),
      .resetb       (resetb),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .bit_i        (bit_i),
      .bit_valid_i  (bit_valid_i),
      .word_o       (word_o),
      .word_ready_i (word_ready_i),
      .word_valid_o (word_valid_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode  = M_IDLE;
      m_nbits = 0;
      m_idle  = 0;
      m_word  = '0;
      m_err   = 1'b0;
   endtask

   // One clock edge of frame behaviour, using the inputs present at the edge
   task automatic model_step();
      m_err = 1'b0;
      if (abort_i) begin
         m_mode  = M_IDLE;
         m_nbits = 0;
         m_idle  = 0;
      end else if (m_mode == M_IDLE) begin
         if (start_i) begin
            m_mode  = M_SHIFT;
            m_nbits = 0;
            m_idle  = 0;
         end
      end else if (m_mode == M_SHIFT) begin
         if (bit_valid_i) begin
            m_word  = {m_word[W-2:0], bit_i};
            m_nbits = m_nbits + 1;
            m_idle  = 0;
            if (m_nbits == W) m_mode = M_HOLD;
         end else begin
            m_idle = m_idle + 1;
            if (m_idle == TMO) begin
               m_mode  = M_IDLE;
               m_err   = 1'b1;
               m_nbits = 0;
               m_idle  = 0;
            end
         end
      end else begin
         if (word_ready_i) begin
            m_mode  = start_i ? M_SHIFT : M_IDLE;
            m_nbits = 0;
            m_idle  = 0;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, "_word"},  32'(word_o),       32'(m_word));
      check_eq({tag, "_valid"}, 32'(word_valid_o), 32'(m_mode == M_HOLD));
      check_eq({tag, "_busy"},  32'(busy_o),       32'(m_mode != M_IDLE));
      check_eq({tag, "_err"},   32'(err_o),        32'(m_err));
   endtask

   task automatic cycle(input logic s, input logic a, input logic b, input logic v,
                        input logic r, input string tag);
      start_i      = s;
      abort_i      = a;
      bit_i        = b;
      bit_valid_i  = v;
      word_ready_i = r;
      @(posedge clk);
      model_step();
      #1;
      compare_all(tag);
   endtask

   task automatic send_bits(input logic [W-1:0] w, input int n, input string tag);
      for (int i = 0; i < n; i++)
         cycle(1'b0, 1'b0, w[W-1-i], 1'b1, 1'b0, tag);
   endtask

   task automatic apply_reset();
      #2;
      resetb = 1'b0;
      model_reset();
      #1;
      compare_all("async_rst");
      @(posedge clk);
      #1;
      resetb = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetb       = 1'b0;
      start_i      = 1'b0;
      abort_i      = 1'b0;
      bit_i        = 1'b0;
      bit_valid_i  = 1'b0;
      word_ready_i = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      compare_all("reset");
      resetb = 1'b1;

      // Single frame 0xA5C3, then acceptance
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "a5_start");
      send_bits(16'hA5C3, W, "a5_bits");
      check_eq("a5_word_const", 32'(word_o), 32'h0000_A5C3);
      check_eq("a5_valid_const", 32'(word_valid_o), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "a5_accept");
      check_eq("a5_idle_after", 32'(busy_o), 32'd0);

      // Frame 0x1234 held for 10 cycles of back-pressure
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "h_start");
      send_bits(16'h1234, W, "h_bits");
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, 1'b0, i[0], i[1], 1'b0, "h_hold");
         check_eq("h_hold_word_const", 32'(word_o), 32'h0000_1234);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "h_accept");
      check_eq("h_valid_after", 32'(word_valid_o), 32'd0);

      // Back-to-back: accept 0xFFFF with start, then 0x0001
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "b_start");
      send_bits(16'hFFFF, W, "b_bits1");
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "b_accept_start");
      check_eq("b_no_idle_busy", 32'(busy_o), 32'd1);
      send_bits(16'h0001, W, "b_bits2");
      check_eq("b_word2_const", 32'(word_o), 32'h0000_0001);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b_accept2");

      // Timeout after 5 bits and 4 idle cycles
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t_start");
      send_bits(16'hB800, 5, "t_bits");
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t_idle");
      check_eq("t_err_const", 32'(err_o), 32'd1);
      check_eq("t_busy_const", 32'(busy_o), 32'd0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t_after");
      check_eq("t_err_one_cycle", 32'(err_o), 32'd0);

      // Valid bit on the 4th idle cycle wins over timeout
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "tw_start");
      send_bits(16'h5000, 5, "tw_bits");
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tw_idle");
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "tw_save");
      check_eq("tw_err_const", 32'(err_o), 32'd0);
      check_eq("tw_busy_const", 32'(busy_o), 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "tw_abort");

      // Abort after 8 bits with a valid bit in the abort cycle
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ab_start");
      send_bits(16'hC300, 8, "ab_bits");
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "ab_abort");
      check_eq("ab_busy_const", 32'(busy_o), 32'd0);
      check_eq("ab_err_const", 32'(err_o), 32'd0);

      // Reset mid-frame, then bits without start are ignored
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "r_start");
      send_bits(16'hFF00, 8, "r_bits");
      apply_reset();
      check_eq("r_word_zero", 32'(word_o), 32'd0);
      send_bits(16'hFFFF, W, "r_nostart");
      check_eq("r_word_still_zero", 32'(word_o), 32'd0);
      check_eq("r_busy_zero", 32'(busy_o), 32'd0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 3),
               1'($urandom), ($urandom_range(0, 99) < 75),
               ($urandom_range(0, 99) < 30), "rnd");
         if ($urandom_range(0, 999) == 0) apply_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_load_ctrl.md
SERIAL_LOAD_CTRL -- requirements
Module: serial_load_ctrl

Interface
REQ-001 Parameter WORD_W, default 16, shifted word width in bits.
REQ-002 Parameter TIMEOUT, default 255, max idle cycles between bits before the frame is abandoned; legal range 1..255.
REQ-003 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port resetb  in  1  asynchronous, active-low reset.
REQ-005 Port start_i  in  1  request to begin capturing one WORD_W-bit frame.
REQ-006 Port abort_i  in  1  cancel any frame in progress.
REQ-007 Port bit_i  in  1  serial data bit.
REQ-008 Port bit_valid_i  in  1  qualifies bit_i for the current cycle.
REQ-009 Port word_o  out  WORD_W  assembled word; the first received bit lands in word_o[WORD_W-1].
REQ-010 Port word_valid_o  out  1  word_o holds a complete frame.
REQ-011 Port word_ready_i  in  1  consumer accepts word_o when high with word_valid_o.
REQ-012 Port busy_o  out  1  high in any state other than IDLE.
REQ-013 Port err_o  out  1  one-cycle pulse on timeout abandonment.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT, HOLD.
REQ-015 In IDLE, start_i=1 SHALL move to SHIFT next cycle, with the bit counter and the idle timer cleared.
REQ-016 start_i SHALL be ignored in SHIFT, and in HOLD except as REQ-021 allows.
REQ-017 Shift enable SHALL equal bit_valid_i in SHIFT and 0 in every other state; bit_valid_i outside SHIFT SHALL be ignored.
REQ-018 Each enabled cycle SHALL shift the word one place toward the MSB, insert bit_i at bit 0, and increment the bit counter (width clog2(WORD_W)+1).
REQ-019 The WORD_W-th valid bit SHALL move SHIFT to HOLD next cycle; word_valid_o SHALL rise that cycle, so latency from last valid bit to word_valid_o is 1 clk.
REQ-020 In HOLD, word_o SHALL stay stable and word_valid_o SHALL stay high until word_ready_i=1.
REQ-021 On acceptance (HOLD with word_ready_i=1), next state SHALL be SHIFT if start_i=1 that cycle (back-to-back frame, counter and timer cleared), else IDLE.
REQ-022 In SHIFT, the idle timer SHALL increment on each cycle with bit_valid_i=0 and clear on each cycle with bit_valid_i=1.
REQ-023 A valid bit in the cycle the timer would reach TIMEOUT SHALL win: no timeout occurs.
REQ-024 When the timer reaches TIMEOUT, the block SHALL pulse err_o for exactly 1 cycle, return to IDLE and clear the counter; word_o keeps the partial content and word_valid_o stays 0.
REQ-025 abort_i=1 SHALL force IDLE next cycle from any state, with priority over start, completion, acceptance and timeout.
REQ-026 In an abort cycle, shift enable SHALL be 0 and err_o SHALL NOT pulse.
REQ-027 word_valid_o SHALL never be high outside HOLD.
REQ-028 busy_o and word_valid_o SHALL be registered-state decodes, free of combinational paths from inputs.

Reset
REQ-029 resetb=0 SHALL immediately force IDLE, counter 0, timer 0, word_o 0, word_valid_o 0, busy_o 0 and err_o 0, regardless of clk.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release, the first frame SHALL need a fresh start_i.

Structure
REQ-031 A shared package SHALL hold the state enum typedef (IDLE/SHIFT/HOLD) and the default word-width constant (16).
REQ-032 The datapath SHALL be one instance of the existing 16-bit shift_register sub-module.
REQ-033 That instance SHALL have its enable driven by the REQ-017 shift enable and its clock and reset shared with this block.
REQ-034 This block SHALL contain only the FSM, bit counter and idle timer.

Verification
REQ-035 Reset, then start_i pulse, then 16 consecutive valid bits of 0xA5C3 MSB-first -> word_valid_o high 1 cycle after the 16th bit, word_o=0xA5C3, busy_o=1 throughout.
REQ-036 Complete frame 0x1234 with word_ready_i held 0 for 10 cycles, then 1 -> word_o stable at 0x1234 all 10 cycles; IDLE next cycle after acceptance.
REQ-037 Accept frame 0xFFFF with start_i=1 in the same cycle, then send 0x0001 -> direct HOLD->SHIFT with no IDLE cycle; second word_o=0x0001.
REQ-038 TIMEOUT=4: start, 5 valid bits, 4 idle cycles -> err_o single pulse, IDLE, word_valid_o never high. Repeat with a valid bit at idle cycle 4 -> no err_o.
REQ-039 abort_i asserted after 8 bits, with bit_valid_i=1 in the abort cycle -> IDLE next cycle, no shift in the abort cycle, no err_o.
REQ-040 resetb low mid-frame after 8 bits -> outputs 0 asynchronously; after release, bits without start_i are ignored (word_o stays 0).
